mem_bus_arbiter: RTL and testbench
==================================

// Module: mem_bus_arbiter
// PURPOSE
//   Shares the single DataMem/Peripheral access port of the MEM stage between two requesters.
//   Port 0 is the CPU MEM stage; port 1 is a UART/DMA loader.
//   The CPU has fixed priority. A starvation counter guarantees DMA a slot, and locked DMA bursts are bounded.
//   cpu_stall tells the pipeline to hold its MEM stage and all earlier stages for the cycle.
// PARAMETERS
//   AW        32  address width (bit 30 selects Peripheral, decoded downstream, not here)
//   DW        32  data width
//   MAX_WAIT  4   consecutive denied DMA cycles before DMA pre-empts CPU (1..15)
//   BURST_MAX 8   max beats DMA may hold under dma_lock (1..255)
// PORTS
//   clk        in   1   CPU clock (divided clock domain)
//   reset      in   1   asynchronous, active-low reset
//   cpu_rd     in   1   CPU MEM-stage read request
//   cpu_wr     in   1   CPU MEM-stage write request
//   cpu_addr   in   AW  CPU address
//   cpu_wdata  in   DW  CPU write data
//   cpu_rdata  out  DW  read data to CPU (mem_rdata when CPU granted, else 0)
//   cpu_stall  out  1   CPU access pending and not granted this cycle
//   dma_req    in   1   DMA access request (held until granted)
//   dma_wr     in   1   1=write, 0=read; valid with dma_req
//   dma_lock   in   1   request burst ownership; sampled on each granted beat
//   dma_addr   in   AW  DMA address
//   dma_wdata  in   DW  DMA write data
//   dma_gnt    out  1   DMA beat performed this cycle
//   dma_rdata  out  DW  read data to DMA (mem_rdata when DMA granted, else 0)
//   mem_rd     out  1   to memory/peripheral
//   mem_wr     out  1   to memory/peripheral
//   mem_addr   out  AW  to memory/peripheral
//   mem_wdata  out  DW  to memory/peripheral
//   mem_rdata  in   DW  combinational read data from memory/peripheral
// BEHAVIOUR
//   - Grant is combinational from the current requests and the registered state, so accesses have zero added latency.
//   - Writes commit at the next clk edge; reads return in the same cycle.
//   - cpu_req = cpu_rd|cpu_wr. Exactly one owner per cycle. The non-owner sees gnt/stall; the mux selects the owner.
//   - States: ST_CPU (reset), ST_LOCK, ST_YIELD.
//   - ST_CPU:
//       grant DMA if dma_req & (~cpu_req | wait_cnt==MAX_WAIT); otherwise grant CPU if cpu_req.
//       On a granted DMA beat with dma_lock=1: go to ST_LOCK, beat_cnt<=1.
//   - ST_LOCK: DMA owns the port; cpu_stall=cpu_req.
//       Beat granted when dma_req=1. dma_req=0 is an idle slot: beat_cnt unchanged, no mem access.
//       Exit to ST_YIELD when a granted beat has dma_lock=0, or beat_cnt reaches BURST_MAX.
//   - ST_YIELD: one cycle; the CPU wins any conflict, DMA is granted only if ~cpu_req. Next state is ST_CPU.
//   - wait_cnt (4b): +1 each cycle dma_req & ~dma_gnt, saturating at MAX_WAIT; cleared on dma_gnt.
//     Held (not incremented) in ST_YIELD.
//   - cpu_rd & cpu_wr together is treated as a write (mem_rd=0).
//   - Idle (no grant): mem_rd=mem_wr=0; mem_addr/mem_wdata=0.
//   - Reset values: state=ST_CPU, wait_cnt=0, beat_cnt=0.
//     With all requests low after reset, every output is 0.
//   - Reset mid-burst: asserting reset aborts immediately; no write issued in that cycle; state returns to ST_CPU.
// CONFIGURATION
//   ARB_PERF_EN defined: adds outputs
//     perf_stall[31:0]  counts cycles with cpu_stall=1, wrapping 0xFFFFFFFF->0
//     perf_beats[31:0]  counts DMA beats, wrapping 0xFFFFFFFF->0
//   Both counters reset to 0.
//   ARB_PERF_EN undefined: ports and counters are absent; arbitration is identical.
// STRUCTURE
//   - Package arb_pkg: state encoding (ST_CPU=2'd0, ST_LOCK=2'd1, ST_YIELD=2'd2), OWNER_NONE/CPU/DMA constants.
//   - Sub-module arb_sat_counter (width, max, inc, clr): used for wait_cnt and beat_cnt.
//   - Grant logic and mux stay in the top-level module.
// TESTING
//   1. CPU only: cpu_rd, addr 0x10 for 5 cycles -> mem_rd=1 each cycle, cpu_stall=0, dma_gnt=0.
//   2. Conflict: dma_req and cpu_wr held continuously, MAX_WAIT=4 ->
//      CPU granted cycles 0-3; DMA granted cycle 4 with cpu_stall=1; pattern repeats every 5 cycles.
//   3. Burst: dma_lock=1 for 10 beats, BURST_MAX=8, cpu_rd high ->
//      8 DMA beats, then ST_YIELD grants CPU for one cycle; DMA resumes per ST_CPU rules.
//   4. Burst end: dma_lock drops on beat 3 -> ST_YIELD next cycle; beat 3 itself is performed.
//   5. Reset asserted during ST_LOCK with dma_wr=1 -> mem_wr=0 immediately; after release state=ST_CPU.
//   6. ARB_PERF_EN: scenario 2 for 50 cycles -> perf_stall=10, perf_beats=10.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared definitions for the MEM-stage bus arbiter: FSM state encoding,
// port-owner codes and the owner-select helper.
package arb_pkg;

  typedef enum logic [1:0] {
    ST_CPU   = 2'd0,
    ST_LOCK  = 2'd1,
    ST_YIELD = 2'd2
  } arb_state_e;

  localparam logic [1:0] OWNER_NONE = 2'd0;
  localparam logic [1:0] OWNER_CPU  = 2'd1;
  localparam logic [1:0] OWNER_DMA  = 2'd2;

  // A DMA grant always excludes a CPU grant, so DMA is checked first.
  function automatic logic [1:0] owner_sel(input logic cpu_gnt, input logic dma_gnt);
    logic [1:0] own;
    if (dma_gnt) begin
      own = OWNER_DMA;
    end else if (cpu_gnt) begin
      own = OWNER_CPU;
    end else begin
      own = OWNER_NONE;
    end
    return own;
  endfunction

endpackage

// File: rtl/arb_sat_counter.sv
// Saturating up-counter with synchronous clear; clr and inc together load 1
// (used to restart a burst count on its first beat).
module arb_sat_counter #(
  parameter int W   = 4,
  parameter int MAX = 4
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  localparam logic [W-1:0] MAX_C  = W'(MAX);
  localparam logic [W-1:0] ONE_C  = W'(1);
  localparam logic [W-1:0] ZERO_C = W'(0);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: clear (optionally restarting at 1), else saturating increment.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      if (inc_i) begin
        cnt_d = ONE_C;
      end else begin
        cnt_d = ZERO_C;
      end
    end else if (inc_i && (cnt_q < MAX_C)) begin
      cnt_d = cnt_q + ONE_C;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= ZERO_C;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares the MEM-stage memory/peripheral port between the CPU (fixed priority) and a
// DMA loader, with a starvation guarantee and bounded locked bursts. Macro ARB_PERF_EN adds perf counters.
module mem_bus_arbiter
  import arb_pkg::*;
#(
  parameter int AW        = 32,
  parameter int DW        = 32,
  parameter int MAX_WAIT  = 4,
  parameter int BURST_MAX = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_rd,
  input  logic          cpu_wr,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_stall,
  input  logic          dma_req,
  input  logic          dma_wr,
  input  logic          dma_lock,
  input  logic [AW-1:0] dma_addr,
  input  logic [DW-1:0] dma_wdata,
  output logic          dma_gnt,
  output logic [DW-1:0] dma_rdata,
  output logic          mem_rd,
  output logic          mem_wr,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
`ifdef ARB_PERF_EN
  ,
  output logic [31:0]   perf_stall,
  output logic [31:0]   perf_beats
`endif
);

  localparam logic [3:0] WAIT_MAX_C  = 4'(MAX_WAIT);
  localparam logic [7:0] BURST_MAX_C = 8'(BURST_MAX);

  arb_state_e state_q;

  logic       cpu_req_s;
  logic       cpu_gnt_s;
  logic       dma_gnt_s;
  logic [1:0] owner_s;
  logic [3:0] wait_cnt_s;
  logic [7:0] beat_cnt_s;
  logic [7:0] beat_next_s;
  logic       wait_inc_s;
  logic       beat_clr_s;
  logic       beat_inc_s;

  // Grant decision from live requests and registered state; nothing is granted while reset is low.
  always_comb begin
    cpu_req_s = cpu_rd | cpu_wr;
    dma_gnt_s = 1'b0;
    cpu_gnt_s = 1'b0;
    if (reset) begin
      case (state_q)
        ST_CPU: begin
          dma_gnt_s = dma_req & (~cpu_req_s | (wait_cnt_s == WAIT_MAX_C));
          cpu_gnt_s = cpu_req_s & ~dma_gnt_s;
        end
        ST_LOCK: begin
          dma_gnt_s = dma_req;
          cpu_gnt_s = 1'b0;
        end
        ST_YIELD: begin
          cpu_gnt_s = cpu_req_s;
          dma_gnt_s = dma_req & ~cpu_req_s;
        end
        default: begin
          dma_gnt_s = 1'b0;
          cpu_gnt_s = 1'b0;
        end
      endcase
    end else begin
      dma_gnt_s = 1'b0;
      cpu_gnt_s = 1'b0;
    end
  end

  assign dma_gnt   = dma_gnt_s;
  assign cpu_stall = reset & cpu_req_s & ~cpu_gnt_s;
  assign owner_s   = owner_sel(cpu_gnt_s, dma_gnt_s);

  // Port mux: the owner drives the memory side and receives read data; idle drives zeros.
  always_comb begin
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    cpu_rdata = '0;
    dma_rdata = '0;
    case (owner_s)
      OWNER_CPU: begin
        mem_rd    = cpu_rd & ~cpu_wr;
        mem_wr    = cpu_wr;
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
        cpu_rdata = mem_rdata;
      end
      OWNER_DMA: begin
        mem_rd    = ~dma_wr;
        mem_wr    = dma_wr;
        mem_addr  = dma_addr;
        mem_wdata = dma_wdata;
        dma_rdata = mem_rdata;
      end
      default: begin
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
      end
    endcase
  end

  // Starvation counter is frozen during the yield cycle so the CPU's slot does not count against it.
  assign wait_inc_s = dma_req & ~dma_gnt_s & (state_q != ST_YIELD);
  assign beat_clr_s = (state_q == ST_CPU) & dma_gnt_s;
  assign beat_inc_s = dma_gnt_s & (((state_q == ST_CPU) & dma_lock) | (state_q == ST_LOCK));
  assign beat_next_s = beat_cnt_s + 8'd1;

  arb_sat_counter #(
    .W   (4),
    .MAX (MAX_WAIT)
  ) u_wait_cnt (
    .clk_i  (clk),
    .rst_ni (reset),
    .clr_i  (dma_gnt_s),
    .inc_i  (wait_inc_s),
    .cnt_o  (wait_cnt_s)
  );

  arb_sat_counter #(
    .W   (8),
    .MAX (BURST_MAX)
  ) u_beat_cnt (
    .clk_i  (clk),
    .rst_ni (reset),
    .clr_i  (beat_clr_s),
    .inc_i  (beat_inc_s),
    .cnt_o  (beat_cnt_s)
  );

  // Ownership FSM: locked bursts enter ST_LOCK and always leave through a single ST_YIELD cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_CPU;
    end else begin
      case (state_q)
        ST_CPU: begin
          if (dma_gnt_s && dma_lock) begin
            state_q <= (BURST_MAX_C == 8'd1) ? ST_YIELD : ST_LOCK;
          end else begin
            state_q <= ST_CPU;
          end
        end
        ST_LOCK: begin
          if (dma_gnt_s && (!dma_lock || (beat_next_s >= BURST_MAX_C))) begin
            state_q <= ST_YIELD;
          end else begin
            state_q <= ST_LOCK;
          end
        end
        ST_YIELD: begin
          state_q <= ST_CPU;
        end
        default: begin
          state_q <= ST_CPU;
        end
      endcase
    end
  end

`ifdef ARB_PERF_EN
  logic [31:0] perf_stall_q;
  logic [31:0] perf_beats_q;

  // Event counters wrap naturally at 32 bits.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_stall_q <= 32'd0;
      perf_beats_q <= 32'd0;
    end else begin
      if (cpu_stall) begin
        perf_stall_q <= perf_stall_q + 32'd1;
      end else begin
        perf_stall_q <= perf_stall_q;
      end
      if (dma_gnt_s) begin
        perf_beats_q <= perf_beats_q + 32'd1;
      end else begin
        perf_beats_q <= perf_beats_q;
      end
    end
  end

  assign perf_stall = perf_stall_q;
  assign perf_beats = perf_beats_q;
`endif

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: vector table, directed multi-cycle scenarios and a
// random run against a behavioural model. Define ARB_PERF_EN to also check the counters.
`timescale 1ns/1ps
module tb_mem_bus_arbiter;

  localparam int AW        = 32;
  localparam int DW        = 32;
  localparam int MAX_WAIT  = 4;
  localparam int BURST_MAX = 8;

  localparam logic [31:0] RD_KEY = 32'h5A5A_0F0F;
  localparam logic [31:0] CPU_A  = 32'h0000_0010;
  localparam logic [31:0] DMA_A  = 32'h4000_0020;
  localparam logic [31:0] CPU_WD = 32'hC0DE_0001;
  localparam logic [31:0] DMA_WD = 32'hD0A0_0002;

  logic          clk = 1'b0;
  logic          reset;
  logic          cpu_rd, cpu_wr, dma_req, dma_wr, dma_lock;
  logic [AW-1:0] cpu_addr, dma_addr, mem_addr;
  logic [DW-1:0] cpu_wdata, dma_wdata, cpu_rdata, dma_rdata, mem_wdata, mem_rdata;
  logic          cpu_stall, dma_gnt, mem_rd, mem_wr;
`ifdef ARB_PERF_EN
  logic [31:0]   perf_stall, perf_beats;
`endif

  assign mem_rdata = mem_addr ^ RD_KEY;

  always #5 clk = ~clk;

  mem_bus_arbiter #(
    .AW(AW), .DW(DW), .MAX_WAIT(MAX_WAIT), .BURST_MAX(BURST_MAX)
  ) dut (
    .clk(clk), .reset(reset),
    .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .dma_req(dma_req), .dma_wr(dma_wr), .dma_lock(dma_lock), .dma_addr(dma_addr),
    .dma_wdata(dma_wdata), .dma_gnt(dma_gnt), .dma_rdata(dma_rdata),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
`ifdef ARB_PERF_EN
    , .perf_stall(perf_stall), .perf_beats(perf_beats)
`endif
  );

  int errors = 0;
  int checks = 0;

  // Behavioural model: DMA waiting count, burst in progress with beats used, pending yield slot.
  int m_waited, m_beats, n_stall, n_beats;
  bit m_burst, m_yield;
  logic        e_gnt, e_stall, e_rd, e_wr;
  logic [31:0] e_addr, e_wdata, e_cpu_rdata, e_dma_rdata;

  typedef struct {
    logic       c_rd, c_wr, d_req, d_wr;
    logic       x_gnt, x_stall, x_rd, x_wr;
    logic [1:0] x_own;
  } vec_t;
  vec_t vt[9];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_waited = 0; m_beats = 0; m_burst = 0; m_yield = 0;
    n_stall = 0; n_beats = 0;
  endtask

  task automatic model_eval();
    bit creq, dg, cg;
    creq = cpu_rd || cpu_wr;
    if (m_burst)      dg = dma_req;
    else if (m_yield) dg = dma_req && !creq;
    else              dg = dma_req && (!creq || m_waited >= MAX_WAIT);
    cg = creq && !dg && !m_burst;
    e_gnt = dg; e_stall = creq && !cg;
    e_rd = 1'b0; e_wr = 1'b0; e_addr = 32'h0; e_wdata = 32'h0;
    if (cg) begin
      e_wr = cpu_wr; e_rd = cpu_rd && !cpu_wr; e_addr = cpu_addr; e_wdata = cpu_wdata;
    end else if (dg) begin
      e_wr = dma_wr; e_rd = !dma_wr; e_addr = dma_addr; e_wdata = dma_wdata;
    end
    e_cpu_rdata = cg ? (e_addr ^ RD_KEY) : 32'h0;
    e_dma_rdata = dg ? (e_addr ^ RD_KEY) : 32'h0;
  endtask

  task automatic model_advance();
    if (e_gnt) begin
      m_waited = 0; n_beats++;
    end else if (dma_req && !m_yield && m_waited < MAX_WAIT) begin
      m_waited++;
    end
    if (e_stall) n_stall++;
    if (m_burst) begin
      if (e_gnt) begin
        m_beats++;
        if (!dma_lock || m_beats >= BURST_MAX) begin m_burst = 0; m_yield = 1; end
      end
    end else if (m_yield) begin
      m_yield = 0;
    end else if (e_gnt && dma_lock) begin
      m_beats = 1;
      if (BURST_MAX <= 1) m_yield = 1; else m_burst = 1;
    end
  endtask

  // Call at the negative edge with inputs stable.
  task automatic model_check(input string tag);
    model_eval();
    check({tag, ".dma_gnt"},   dma_gnt,   e_gnt);
    check({tag, ".cpu_stall"}, cpu_stall, e_stall);
    check({tag, ".mem_rd"},    mem_rd,    e_rd);
    check({tag, ".mem_wr"},    mem_wr,    e_wr);
    check({tag, ".mem_addr"},  mem_addr,  e_addr);
    check({tag, ".mem_wdata"}, mem_wdata, e_wdata);
    check({tag, ".cpu_rdata"}, cpu_rdata, e_cpu_rdata);
    check({tag, ".dma_rdata"}, dma_rdata, e_dma_rdata);
    model_advance();
  endtask

  task automatic drive(input logic crd, input logic cwr, input logic dreq, input logic dwr, input logic dlk);
    cpu_rd = crd; cpu_wr = cwr; dma_req = dreq; dma_wr = dwr; dma_lock = dlk;
  endtask

  // Leaves the bench 1 ns after a rising edge with reset released.
  task automatic do_reset();
    reset = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cpu_addr = CPU_A; dma_addr = DMA_A; cpu_wdata = CPU_WD; dma_wdata = DMA_WD;
    model_reset();
    @(posedge clk); #1;
    reset = 1'b1;
  endtask

  task automatic step(input string tag);
    @(negedge clk);
    model_check(tag);
    @(posedge clk); #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ea;
    bit pend;

    vt[0] = '{1'b0, 1'b0, 1'b0, 1'b0,  1'b0, 1'b0, 1'b0, 1'b0, 2'd0};
    vt[1] = '{1'b1, 1'b0, 1'b0, 1'b0,  1'b0, 1'b0, 1'b1, 1'b0, 2'd1};
    vt[2] = '{1'b0, 1'b1, 1'b0, 1'b0,  1'b0, 1'b0, 1'b0, 1'b1, 2'd1};
    vt[3] = '{1'b1, 1'b1, 1'b0, 1'b0,  1'b0, 1'b0, 1'b0, 1'b1, 2'd1};
    vt[4] = '{1'b0, 1'b0, 1'b1, 1'b0,  1'b1, 1'b0, 1'b1, 1'b0, 2'd2};
    vt[5] = '{1'b0, 1'b0, 1'b1, 1'b1,  1'b1, 1'b0, 1'b0, 1'b1, 2'd2};
    vt[6] = '{1'b1, 1'b0, 1'b1, 1'b0,  1'b0, 1'b0, 1'b1, 1'b0, 2'd1};
    vt[7] = '{1'b0, 1'b1, 1'b1, 1'b1,  1'b0, 1'b0, 1'b0, 1'b1, 2'd1};
    vt[8] = '{1'b0, 1'b0, 1'b0, 1'b1,  1'b0, 1'b0, 1'b0, 1'b0, 2'd0};

    // Reset state: every output low while in reset with no requests.
    reset = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cpu_addr = CPU_A; dma_addr = DMA_A; cpu_wdata = CPU_WD; dma_wdata = DMA_WD;
    @(negedge clk);
    check("rst.dma_gnt", dma_gnt, 1'b0);
    check("rst.cpu_stall", cpu_stall, 1'b0);
    check("rst.mem_rd", mem_rd, 1'b0);
    check("rst.mem_wr", mem_wr, 1'b0);
    check("rst.mem_addr", mem_addr, 32'h0);
    check("rst.cpu_rdata", cpu_rdata, 32'h0);
`ifdef ARB_PERF_EN
    check("rst.perf_stall", perf_stall, 32'h0);
    check("rst.perf_beats", perf_beats, 32'h0);
`endif

    // Single-cycle vectors from the reset state.
    for (int i = 0; i < 9; i++) begin
      do_reset();
      drive(vt[i].c_rd, vt[i].c_wr, vt[i].d_req, vt[i].d_wr, 1'b0);
      @(negedge clk);
      ea = (vt[i].x_own == 2'd1) ? CPU_A : (vt[i].x_own == 2'd2) ? DMA_A : 32'h0;
      check($sformatf("vec%0d.dma_gnt", i), dma_gnt, vt[i].x_gnt);
      check($sformatf("vec%0d.cpu_stall", i), cpu_stall, vt[i].x_stall);
      check($sformatf("vec%0d.mem_rd", i), mem_rd, vt[i].x_rd);
      check($sformatf("vec%0d.mem_wr", i), mem_wr, vt[i].x_wr);
      check($sformatf("vec%0d.mem_addr", i), mem_addr, ea);
      check($sformatf("vec%0d.cpu_rdata", i), cpu_rdata, (vt[i].x_own == 2'd1) ? (CPU_A ^ RD_KEY) : 32'h0);
      check($sformatf("vec%0d.dma_rdata", i), dma_rdata, (vt[i].x_own == 2'd2) ? (DMA_A ^ RD_KEY) : 32'h0);
      @(posedge clk); #1;
    end

    // CPU-only reads.
    do_reset();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("s1.mem_rd", mem_rd, 1'b1);
      check("s1.stall", cpu_stall, 1'b0);
      model_check("s1");
      @(posedge clk); #1;
    end

    // Continuous conflict: DMA wins every fifth cycle.
    do_reset();
    drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      check($sformatf("s2.gnt[%0d]", i), dma_gnt, (i % 5) == 4);
      check($sformatf("s2.stall[%0d]", i), cpu_stall, (i % 5) == 4);
      model_check("s2");
      @(posedge clk); #1;
    end

    // Locked burst capped at BURST_MAX, then one yield slot for the CPU.
    do_reset();
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      check($sformatf("s3.gnt[%0d]", i), dma_gnt, ((i >= 4) && (i <= 11)) || (i == 17));
      model_check("s3");
      @(posedge clk); #1;
    end

    // Burst released on beat 3; that beat still happens.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(i > 0, 1'b0, 1'b1, 1'b1, i < 2);
      @(negedge clk);
      check($sformatf("s4.gnt[%0d]", i), dma_gnt, i < 3);
      check($sformatf("s4.stall[%0d]", i), cpu_stall, (i == 1) || (i == 2));
      model_check("s4");
      @(posedge clk); #1;
    end

    // Reset asserted inside a locked write burst.
    do_reset();
    drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    step("s5a");
    #1;
    check("s5.pre_wr", mem_wr, 1'b1);
    reset = 1'b0;
    #1;
    check("s5.rst_wr", mem_wr, 1'b0);
    check("s5.rst_gnt", dma_gnt, 1'b0);
    model_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    check("s5.post_gnt", dma_gnt, 1'b0);
    check("s5.post_rd", mem_rd, 1'b1);
    model_check("s5b");
    @(posedge clk); #1;

    // Locked idle slots: dma_req low inside a burst performs no access and keeps CPU stalled.
    do_reset();
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    step("s7a");
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    step("s7b");
    step("s7c");
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    step("s7d");
    step("s7e");

`ifdef ARB_PERF_EN
    do_reset();
    drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 50; i++) step("s6");
    @(negedge clk);
    check("s6.perf_stall", perf_stall, 32'd10);
    check("s6.perf_beats", perf_beats, 32'd10);
    @(posedge clk); #1;
`endif

    // Random traffic; a DMA request is held with the same attributes until granted.
    do_reset();
    pend = 1'b0;
    for (int i = 0; i < 500; i++) begin
      cpu_rd = ($urandom_range(0, 9) < 5);
      cpu_wr = ($urandom_range(0, 9) < 3);
      cpu_addr = $urandom;
      cpu_wdata = $urandom;
      dma_lock = ($urandom_range(0, 3) != 0);
      if (!pend) begin
        dma_req = ($urandom_range(0, 1) == 1);
        dma_wr = ($urandom_range(0, 1) == 1);
        dma_addr = $urandom;
        dma_wdata = $urandom;
      end
      step("rnd");
      pend = dma_req && !e_gnt;
    end
`ifdef ARB_PERF_EN
    @(negedge clk);
    check("rnd.perf_stall", perf_stall, n_stall);
    check("rnd.perf_beats", perf_beats, n_beats);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
